// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, IF/ID prediction register and decode-stage recovery.
// Optional `BPU_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor #(
    parameter int PC_W       = 10,
    parameter int INDEX_BITS = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_IF,
    input  logic            hold,
    input  logic            branch_ID,
    input  logic            taken_ID,
    input  logic [PC_W-1:0] target_ID,
    output logic            pred_taken_IF,
    output logic [PC_W-1:0] pred_pc_IF,
    output logic            mispredict,
    output logic [PC_W-1:0] recover_pc
`ifdef BPU_STATS_EN
    ,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispredict_cnt
`endif
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = PC_W - INDEX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [PC_W-1:0]    pc_id_q, pred_target_id_q;
    logic               pred_taken_id_q;

    logic [INDEX_BITS-1:0] idx_if, idx_id;
    logic                  hit_if, hit_id, mis_raw, train, inval;
    logic [1:0]            ctr_d;
    logic [PC_W-1:0]       seq_pc_id;

    assign idx_if        = pc_IF[INDEX_BITS-1:0];
    assign hit_if        = valid_q[idx_if] && (tag_q[idx_if] == pc_IF[PC_W-1:INDEX_BITS]);
    assign pred_taken_IF = hit_if && ctr_q[idx_if][1];
    assign pred_pc_IF    = pred_taken_IF ? tgt_q[idx_if] : pc_IF + 1'b1;

    assign idx_id    = pc_id_q[INDEX_BITS-1:0];
    assign hit_id    = valid_q[idx_id] && (tag_q[idx_id] == pc_id_q[PC_W-1:INDEX_BITS]);
    assign seq_pc_id = pc_id_q + 1'b1;

    always_comb begin
        mis_raw    = pred_taken_id_q;
        recover_pc = seq_pc_id;
        if (branch_ID) begin
            if (taken_ID) begin
                recover_pc = target_ID;
                mis_raw    = !pred_taken_id_q || (pred_target_id_q != target_ID);
            end else begin
                mis_raw    = pred_taken_id_q;
            end
        end
    end

    assign mispredict = mis_raw && !hold;
    assign train      = branch_ID && !hold;
    // A predicted-taken non-branch means the entry is stale or aliased; drop it.
    assign inval      = !branch_ID && pred_taken_id_q && !hold;

    always_comb begin
        ctr_d = ctr_q[idx_id];
        if (taken_ID && ctr_q[idx_id] != 2'b11)
            ctr_d = ctr_q[idx_id] + 2'b01;
        else if (!taken_ID && ctr_q[idx_id] != 2'b00)
            ctr_d = ctr_q[idx_id] - 2'b01;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (train) begin
            if (hit_id) begin
                ctr_q[idx_id] <= ctr_d;
                if (taken_ID) tgt_q[idx_id] <= target_ID;
            end else if (taken_ID) begin
                valid_q[idx_id] <= 1'b1;
                tag_q[idx_id]   <= pc_id_q[PC_W-1:INDEX_BITS];
                tgt_q[idx_id]   <= target_ID;
                ctr_q[idx_id]   <= 2'b10;
            end
        end else if (inval) begin
            valid_q[idx_id] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_id_q          <= '0;
            pred_taken_id_q  <= 1'b0;
            pred_target_id_q <= '0;
        end else if (!hold) begin
            pc_id_q          <= pc_IF;
            pred_taken_id_q  <= pred_taken_IF && !mispredict;
            pred_target_id_q <= tgt_q[idx_if];
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (train && branch_cnt != 16'hFFFF)
                branch_cnt <= branch_cnt + 16'd1;
            if (mispredict && mispredict_cnt != 16'hFFFF)
                mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a table-level behavioural model.
module tb_branch_predictor;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] pc_IF = '0;
    logic       hold = 1'b0;
    logic       branch_ID = 1'b0;
    logic       taken_ID = 1'b0;
    logic [9:0] target_ID = '0;
    logic       pred_taken_IF, mispredict;
    logic [9:0] pred_pc_IF, recover_pc;
`ifdef BPU_STATS_EN
    logic [15:0] branch_cnt, mispredict_cnt;
`endif

    branch_predictor #(.PC_W(10), .INDEX_BITS(5)) dut (
        .clk(clk), .rst(rst), .pc_IF(pc_IF), .hold(hold),
        .branch_ID(branch_ID), .taken_ID(taken_ID), .target_ID(target_ID),
        .pred_taken_IF(pred_taken_IF), .pred_pc_IF(pred_pc_IF),
        .mispredict(mispredict), .recover_pc(recover_pc)
`ifdef BPU_STATS_EN
        , .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit       v;
        bit [4:0] tag;
        bit [9:0] tgt;
        int       ctr;
    } ent_t;

    ent_t     m_tab [32];
    bit [9:0] m_pc_id;
    bit       m_ptk;
    bit [9:0] m_ptgt;
    int       m_bcnt, m_mcnt;

    function automatic bit m_hit(input bit [9:0] pc);
        return m_tab[pc[4:0]].v && m_tab[pc[4:0]].tag == pc[9:5];
    endfunction

    function automatic bit m_pred(input bit [9:0] pc);
        return m_hit(pc) && m_tab[pc[4:0]].ctr >= 2;
    endfunction

    function automatic bit [9:0] m_ppc(input bit [9:0] pc);
        bit [9:0] nxt = pc + 10'd1;
        return m_pred(pc) ? m_tab[pc[4:0]].tgt : nxt;
    endfunction

    function automatic bit m_mis();
        if (hold) return 1'b0;
        if (branch_ID) return taken_ID ? (!m_ptk || m_ptgt != target_ID) : m_ptk;
        return m_ptk;
    endfunction

    function automatic bit [9:0] m_rec();
        bit [9:0] nxt = m_pc_id + 10'd1;
        return (branch_ID && taken_ID) ? target_ID : nxt;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_tab[i] = '{v: 0, tag: 0, tgt: 0, ctr: 1};
            m_pc_id = 0; m_ptk = 0; m_ptgt = 0; m_bcnt = 0; m_mcnt = 0;
        end else if (!hold) begin
            bit       n_ptk, mis;
            bit [9:0] n_tgt;
            int       i;
            mis   = m_mis();
            n_ptk = m_pred(pc_IF) && !mis;
            n_tgt = m_tab[pc_IF[4:0]].tgt;
            if (mis && m_mcnt < 65535) m_mcnt++;
            i = m_pc_id[4:0];
            if (branch_ID) begin
                if (m_bcnt < 65535) m_bcnt++;
                if (m_hit(m_pc_id)) begin
                    m_tab[i].ctr = taken_ID ? ((m_tab[i].ctr < 3) ? m_tab[i].ctr + 1 : 3)
                                            : ((m_tab[i].ctr > 0) ? m_tab[i].ctr - 1 : 0);
                    if (taken_ID) m_tab[i].tgt = target_ID;
                end else if (taken_ID) begin
                    m_tab[i] = '{v: 1, tag: m_pc_id[9:5], tgt: target_ID, ctr: 2};
                end
            end else if (m_ptk) begin
                m_tab[i].v = 0;
            end
            m_pc_id = pc_IF; m_ptk = n_ptk; m_ptgt = n_tgt;
        end
    end

    always @(negedge clk) begin
        chk("pred_taken_IF", {31'd0, pred_taken_IF}, {31'd0, m_pred(pc_IF)});
        chk("pred_pc_IF", {22'd0, pred_pc_IF}, {22'd0, m_ppc(pc_IF)});
        chk("mispredict", {31'd0, mispredict}, {31'd0, m_mis()});
        chk("recover_pc", {22'd0, recover_pc}, {22'd0, m_rec()});
`ifdef BPU_STATS_EN
        chk("branch_cnt", {16'd0, branch_cnt}, m_bcnt);
        chk("mispredict_cnt", {16'd0, mispredict_cnt}, m_mcnt);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit [9:0] pc, input bit br, input bit tk, input bit [9:0] tg, input bit hd);
        @(posedge clk); #1;
        pc_IF = pc; branch_ID = br; taken_ID = tk; target_ID = tg; hold = hd;
        @(negedge clk); #1;
    endtask

    bit [9:0] pool [8] = '{10'h010, 10'h030, 10'h011, 10'h3FF, 10'h000, 10'h01F, 10'h020, 10'h3E0};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        cyc(10'h004, 0, 0, 0, 0);
        chk("d_reset_pt", pred_taken_IF, 0); chk("d_reset_ppc", pred_pc_IF, 10'h005);
        chk("d_reset_mis", mispredict, 0);
        cyc(10'h010, 0, 0, 0, 0);
        cyc(10'h011, 1, 1, 10'h020, 0);
        chk("d_first_mis", mispredict, 1); chk("d_first_rec", recover_pc, 10'h020);
        cyc(10'h010, 0, 0, 0, 0);
        chk("d_alloc_pt", pred_taken_IF, 1); chk("d_alloc_ppc", pred_pc_IF, 10'h020);
        cyc(10'h020, 1, 1, 10'h020, 0);
        chk("d_tk2_mis", mispredict, 0);
        cyc(10'h010, 0, 0, 0, 0);
        cyc(10'h020, 1, 1, 10'h020, 0);
        cyc(10'h010, 0, 0, 0, 0);
        chk("d_sat_pt", pred_taken_IF, 1);
        cyc(10'h020, 1, 0, 0, 0);
        chk("d_nt1_mis", mispredict, 1); chk("d_nt1_rec", recover_pc, 10'h011);
        cyc(10'h010, 0, 0, 0, 0);
        chk("d_weakT_pt", pred_taken_IF, 1);
        cyc(10'h011, 1, 0, 0, 0);
        chk("d_nt2_mis", mispredict, 1);
        cyc(10'h010, 0, 0, 0, 0);
        chk("d_weakNT_pt", pred_taken_IF, 0); chk("d_weakNT_ppc", pred_pc_IF, 10'h011);
        cyc(10'h011, 1, 1, 10'h020, 0);
        cyc(10'h010, 0, 0, 0, 0);
        chk("d_retrain_pt", pred_taken_IF, 1);
        cyc(10'h020, 0, 0, 0, 0);
        chk("d_alias_mis", mispredict, 1); chk("d_alias_rec", recover_pc, 10'h011);
        cyc(10'h010, 0, 0, 0, 0);
        chk("d_inval_pt", pred_taken_IF, 0);
        cyc(10'h011, 1, 1, 10'h020, 0);
        cyc(10'h010, 0, 0, 0, 0);
        cyc(10'h020, 1, 0, 0, 1);
        chk("d_hold_mis", mispredict, 0);
        cyc(10'h010, 1, 0, 0, 1);
        chk("d_hold_mis2", mispredict, 0); chk("d_hold_pt", pred_taken_IF, 1);
        cyc(10'h020, 1, 0, 0, 0);
        chk("d_unhold_mis", mispredict, 1); chk("d_unhold_rec", recover_pc, 10'h011);
        cyc(10'h010, 0, 0, 0, 0);
        chk("d_once_pt0", pred_taken_IF, 0);
        cyc(10'h011, 1, 1, 10'h020, 0);
        cyc(10'h010, 0, 0, 0, 0);
        chk("d_once_pt1", pred_taken_IF, 1);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk); #1;
        chk("d_rst_pt", pred_taken_IF, 0); chk("d_rst_rec", recover_pc, 10'h001);
`ifdef BPU_STATS_EN
        chk("d_rst_bcnt", branch_cnt, 0); chk("d_rst_mcnt", mispredict_cnt, 0);
`endif
        @(posedge clk); #3 rst = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            bit [9:0] pc, tg;
            pc = ($urandom_range(0, 7) == 0) ? 10'($urandom) : pool[$urandom_range(0, 7)];
            tg = ($urandom_range(0, 3) == 0) ? 10'($urandom) : pool[$urandom_range(0, 7)];
            cyc(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tg,
                $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) begin
                @(posedge clk); #3 rst = 1'b0;
                @(posedge clk); #3 rst = 1'b1;
            end
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
